// File: rtl/result_nibble_reader.sv
// Snapshots an 8-bit adder result on a debounced capture press and shows it one nibble at a time,
// toggled by a debounced next press; outputs are registered and update one edge after the press pulse.
module result_nibble_reader #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result,
  input  logic       pb_capture,
  input  logic       pb_next,
  output logic [3:0] led,
  output logic       nib_sel,
  output logic       valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_t;

  logic [1:0] pb_raw;
  logic [1:0] press;

  assign pb_raw = {pb_next, pb_capture};

  // Bit 0 is capture, bit 1 is next. A press pulse fires only on a debounced rising level.
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic             sync1_q, sync2_q, stable_q, press_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mismatch;

    assign mismatch = (sync2_q != stable_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        press_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q <= pb_raw[b];
        sync2_q <= sync1_q;
        press_q <= 1'b0;
        if (!mismatch) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
          press_q  <= sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[b] = press_q;
  end

  state_t     state_q, state_d;
  logic [7:0] snap_q, snap_d;
  logic [3:0] led_q, led_d;
  logic       nib_sel_q, nib_sel_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      snap_q    <= 8'h00;
      led_q     <= 4'h0;
      nib_sel_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      led_q     <= led_d;
      nib_sel_q <= nib_sel_d;
      valid_q   <= valid_d;
    end
  end

  // Outputs are decoded from the next state so they land on the same edge as the transition.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    led_d     = 4'h0;
    nib_sel_d = 1'b0;
    valid_d   = 1'b0;

    if (press[0]) begin
      snap_d  = result;
      state_d = SHOW_LO;
    end else if (press[1]) begin
      case (state_q)
        SHOW_LO: state_d = SHOW_HI;
        SHOW_HI: state_d = SHOW_LO;
        default: state_d = EMPTY;
      endcase
    end

    case (state_d)
      SHOW_LO: begin
        led_d   = snap_d[3:0];
        valid_d = 1'b1;
      end
      SHOW_HI: begin
        led_d     = snap_d[7:4];
        nib_sel_d = 1'b1;
        valid_d   = 1'b1;
      end
      default: begin
        led_d     = 4'h0;
        nib_sel_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  assign led     = led_q;
  assign nib_sel = nib_sel_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_result_nibble_reader.sv
// Bench for result_nibble_reader: directed edge-exact scenarios plus randomized button/result
// traffic, all compared every cycle against a run-length debounce model and a three-state display model.
module tb_result_nibble_reader;

  localparam int DB = 4;

  logic       clk;
  logic       rst_n = 1'b1;
  logic [7:0] result;
  logic       pb_capture;
  logic       pb_next;
  logic [3:0] led;
  logic       nib_sel;
  logic       valid;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  result_nibble_reader #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .result     (result),
    .pb_capture (pb_capture),
    .pb_next    (pb_next),
    .led        (led),
    .nib_sel    (nib_sel),
    .valid      (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [5:0] dut_outs = {valid, nib_sel, led};

  // Reference model: state 0 = nothing held, 1 = low nibble, 2 = high nibble.
  logic [1:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_pr = '0;
  int         m_run[2] = '{0, 0};
  int         m_state  = 0;
  logic [7:0] m_snap   = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_pr = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_state = 0; m_snap = 8'h00;
    end else begin
      if (m_pr[0]) begin
        m_snap  = result;
        m_state = 1;
      end else if (m_pr[1]) begin
        if (m_state == 1) m_state = 2;
        else if (m_state == 2) m_state = 1;
      end
      for (int b = 0; b < 2; b++) begin
        m_pr[b] = 1'b0;
        if (m_s2[b] != m_st[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DB) begin
            m_st[b]  = m_s2[b];
            m_run[b] = 0;
            m_pr[b]  = m_st[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {pb_next, pb_capture};
    end
  end

  function automatic logic [5:0] model_outs();
    case (m_state)
      1:       return {2'b10, m_snap[3:0]};
      2:       return {2'b11, m_snap[7:4]};
      default: return 6'b00_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {valid,nib_sel,led}=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) chk("model_cmp", dut_outs, model_outs());
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Pin must already be high with edge 1 being the next rising edge.
  task automatic edge_check(input string nm, input logic [5:0] pre, input logic [5:0] post);
    repeat (DB + 2) @(posedge clk);
    #2 chk({nm, "_pre"}, dut_outs, pre);
    @(posedge clk);
    #2 chk({nm, "_post"}, dut_outs, post);
    tick();
  endtask

  task automatic next_press(input int hold);
    pb_next = 1'b1;
    tick(hold);
    pb_next = 1'b0;
    tick(DB + 6);
  endtask

  int   hold[2];
  logic lvl[2];

  initial begin
    pb_capture = 1'b0;
    pb_next    = 1'b0;
    result     = 8'h00;
    #1 rst_n   = 1'b0;
    cmp_en     = 1'b1;
    tick(2);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", dut_outs, 6'b00_0000);
    end

    result     = 8'hA5;
    pb_capture = 1'b1;
    edge_check("capture_a5", 6'b00_0000, 6'b10_0101);
    pb_capture = 1'b0;
    result     = 8'h3C;
    tick(DB + 6);
    chk("result_change_ignored", dut_outs, 6'b10_0101);

    next_press(DB + 2);
    chk("next_to_hi", dut_outs, 6'b11_1010);
    next_press(DB + 2);
    chk("next_to_lo", dut_outs, 6'b10_0101);
    next_press(50);
    chk("held_one_toggle", dut_outs, 6'b11_1010);
    next_press(DB - 1);
    chk("glitch_no_toggle", dut_outs, 6'b11_1010);

    result     = 8'hFF;
    pb_capture = 1'b1;
    pb_next    = 1'b1;
    tick(DB + 2);
    pb_capture = 1'b0;
    pb_next    = 1'b0;
    tick(DB + 6);
    chk("simul_capture_wins", dut_outs, 6'b10_1111);
    next_press(DB + 2);
    chk("ff_show_hi", dut_outs, 6'b11_1111);

    pb_capture = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1 chk("async_reset", dut_outs, 6'b00_0000);
    tick(2);
    result = 8'h96;
    rst_n  = 1'b1;
    edge_check("held_through_reset", 6'b00_0000, 6'b10_0110);
    pb_capture = 1'b0;
    tick(DB + 6);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(2);
    next_press(DB + 2);
    chk("next_in_empty", dut_outs, 6'b00_0000);

    hold[0] = 0; hold[1] = 0;
    lvl[0]  = 1'b0; lvl[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 10);
        end
        hold[b]--;
      end
      pb_capture = lvl[0];
      pb_next    = ($urandom_range(0, 15) == 0) ? lvl[0] : lvl[1];
      result     = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/result_nibble_reader.md
RESULT_NIBBLE_READER -- requirements
Module: result_nibble_reader

Interface
REQ-001: Parameter DB_CYCLES, default 16, number of consecutive stable clock cycles required to accept a button level change.
REQ-002: Parameter CNT_W, default 5, debounce counter width; SHALL satisfy 2^CNT_W > DB_CYCLES.
REQ-003: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: result  input  8  adder output {carry, z[6:0]}, sampled only on capture.
REQ-006: pb_capture  input  1  raw asynchronous pushbutton, snapshot result.
REQ-007: pb_next  input  1  raw asynchronous pushbutton, toggle displayed nibble.
REQ-008: led  output  4  displayed nibble of the snapshot.
REQ-009: nib_sel  output  1  0 = low nibble shown, 1 = high nibble shown.
REQ-010: valid  output  1  high while a snapshot is held.

Function
REQ-011: Each button SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012: Each button SHALL have an independent debouncer: a stable level register plus a counter; the counter clears whenever sync2 equals stable.
REQ-013: While sync2 differs from stable, the counter increments each edge; on the edge where the count equals DB_CYCLES-1 with mismatch still present, stable takes sync2 and the counter clears.
REQ-014: A pin held high from edge 1 (the first edge sampling it high) SHALL raise stable on edge DB_CYCLES+2. A press pulse SHALL be high for exactly the one cycle following that edge.
REQ-015: Any mismatch lasting fewer than DB_CYCLES consecutive cycles after sync2 SHALL produce no level change and no press pulse.
REQ-016: A held button SHALL produce exactly one press. Release SHALL be debounced identically and SHALL produce no pulse.
REQ-017: The FSM SHALL have three states: EMPTY, SHOW_LO, SHOW_HI.
REQ-018: On a capture press, from any state: snapshot <= result; state <= SHOW_LO.
REQ-019: On a next press without a capture press: EMPTY->EMPTY, SHOW_LO->SHOW_HI, SHOW_HI->SHOW_LO; snapshot unchanged.
REQ-020: Simultaneous capture and next presses in the same cycle: capture SHALL win (new snapshot, SHOW_LO).
REQ-021: Outputs SHALL be registered and SHALL change on the same edge as the state change, i.e. one edge after the press-pulse cycle begins.
REQ-022: In EMPTY: led=0000, nib_sel=0, valid=0.
REQ-023: In SHOW_LO: led=snapshot[3:0], nib_sel=0, valid=1.
REQ-024: In SHOW_HI: led=snapshot[7:4], nib_sel=1, valid=1.
REQ-025: Changes on result outside a capture press SHALL NOT affect led.
REQ-026: The debounce counter SHALL never exceed DB_CYCLES-1 (no wrap).

Reset
REQ-027: rst_n low SHALL immediately and asynchronously clear: synchronizers, stable levels, counters, snapshot (to 0x00), state (to EMPTY), led=0000, nib_sel=0, valid=0.
REQ-028: Reset asserted mid-debounce or mid-display SHALL discard all progress. A button still held across reset release SHALL be treated as a new press, re-debounced from zero.
REQ-029: No press pulse SHALL be generated by the reset event itself.

Verification (DB_CYCLES=4)
REQ-030: Reset release, no buttons -> led=0000, nib_sel=0, valid=0 for 20 cycles.
REQ-031: result=0xA5, pb_capture held high from edge 1 -> stable rises edge 6; led=0101, nib_sel=0, valid=1 after edge 7; further change of result to 0x3C leaves led=0101.
REQ-032: After REQ-031, pb_next press -> led=1010, nib_sel=1. Second press -> led=0101, nib_sel=0. Button held for 50 cycles -> exactly one toggle.
REQ-033: pb_next high for 3 cycles then low (glitch) -> no toggle. A next press while in EMPTY -> outputs stay 0.
REQ-034: result=0xFF, pb_capture and pb_next driven identically (simultaneous pulses) while in SHOW_HI -> led=1111, nib_sel=0, valid=1.
REQ-035: rst_n pulsed low mid-debounce and while in SHOW_HI -> outputs 0 immediately without a clock edge. A button held through release -> press recognised at edge DB_CYCLES+2 after release.
